alu_issue_stage: RTL

- Decode/issue stage directly upstream of the adder/ALU datapath in the 16-bit RISC core.
- Accepts one instruction per cycle with valid/ready, decodes the opcode and latches the operands.
- Presents registered A, B and 2-bit ALU ctrl (00 ADD, 01 SUB, 10 CMP, 11 RES) plus writeback tags to the execute stage.
- A 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_issue_stage_skid_buf.sv | 61 ++++++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and field positions for the ALU issue stage and its skid buffer.
package alu_pkg;

  localparam int ALU_W    = 16;
  localparam int IMM_BITS = 4;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_CMP  = 4'h2,
    OP_ADDI = 4'h3,
    OP_NOP  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_CMP = 2'b10,
    ALU_RES = 2'b11
  } alu_ctrl_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_ctrl_e        ctrl;
    logic [3:0]       rd;
    logic             rd_we;
    logic             flag_we;
  } issue_t;

  function automatic logic [ALU_W-1:0] zext_imm(input logic [IMM_BITS-1:0] imm);
    return {{(ALU_W-IMM_BITS){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid entry.
// push_ready is registered and reflects only skid occupancy.
module skid_buf #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  T     push_data,
  output logic push_ready,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data
);

  T     out_q, skid_q;
  logic out_v, skid_v, rdy_q;
  logic drain, skid_v_nxt;

  // Output register can take new data this edge if empty or being consumed.
  assign drain = !out_v || pop_ready;

  always_comb begin
    skid_v_nxt = skid_v;
    if (drain)
      skid_v_nxt = 1'b0;
    else if (push_valid && rdy_q)
      skid_v_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      out_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q  <= !skid_v_nxt;
      skid_v <= skid_v_nxt;
      if (drain) begin
        if (skid_v) begin
          out_q <= skid_q;
          out_v <= 1'b1;
        end else if (push_valid && rdy_q) begin
          out_q <= push_data;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (push_valid && rdy_q) begin
        skid_q <= push_data;
      end
    end
  end

  assign push_ready = rdy_q;
  assign pop_valid  = out_v;
  assign pop_data   = out_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: decodes, skid-buffers and presents operands.
// Optional macro ALU_ISSUE_PERF_EN adds saturating issued/illegal counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int IMM_W = IMM_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  output logic [3:0]       rd,
  output logic             rd_we,
  output logic             flag_we,
  output logic             illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      illegal_cnt
`endif
);

  issue_t dec, head;
  logic   legal, bad, accept, issue;

  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    bad       = 1'b0;
    dec.a     = rs1_data;
    dec.rd    = instr[RD_HI:RD_LO];
    case (opcode_e'(instr[OPC_HI:OPC_LO]))
      OP_ADD: begin
        legal     = 1'b1;
        dec.ctrl  = ALU_ADD;
        dec.b     = rs2_data;
        dec.rd_we = 1'b1;
      end
      OP_SUB: begin
        legal     = 1'b1;
        dec.ctrl  = ALU_SUB;
        dec.b     = rs2_data;
        dec.rd_we = 1'b1;
      end
      OP_CMP: begin
        legal       = 1'b1;
        dec.ctrl    = ALU_CMP;
        dec.b       = rs2_data;
        dec.flag_we = 1'b1;
      end
      OP_ADDI: begin
        legal     = 1'b1;
        dec.ctrl  = ALU_ADD;
        dec.b     = {{(WIDTH-IMM_W){1'b0}}, instr[IMM_W-1:0]};
        dec.rd_we = 1'b1;
      end
      OP_NOP: ;
      default: bad = 1'b1;
    endcase
  end

  // NOP and illegal opcodes complete the handshake but never enter the buffer.
  assign accept = in_valid && in_ready;
  assign issue  = out_valid && out_ready;

  skid_buf #(.T(issue_t)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (accept && legal),
    .push_data  (dec),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign alu_a    = head.a;
  assign alu_b    = head.b;
  assign alu_ctrl = head.ctrl;
  assign rd       = head.rd;
  assign rd_we    = head.rd_we;
  assign flag_we  = head.flag_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= accept && bad;
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (issue && issued_cnt != 16'hFFFF)
        issued_cnt <= issued_cnt + 16'd1;
      if (accept && bad && illegal_cnt != 16'hFFFF)
        illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule
